// File: rtl/writeback_pkg.sv
// Shared writeback-stage types.
//
// Contents:
//   word_t, creg_addr_t          basic datapath types
//   decoded_instr_t              compact decoded-instruction tag carried to commit
//   writeback_data_t             memory-stage writeback record (legacy layout)
//   wb_entry_t                   commit-queue record (lane format on the queue ports)
//   wb_store_t                   wb_entry_t without pc, the form the queue buffers
//   WB_CH_MAX                    widest supported commit group
//   wb_entry_from_wbdata()       legacy record -> wb_entry_t
//   wb_pack_store()/wb_unpack_store()  strip / re-attach the pc field
package writeback_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  localparam int WB_CH_MAX = 4;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_MULDIV,
    OP_MTHILO
  } op_class_t;

  typedef struct packed {
    op_class_t  op;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_delay_slot;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t instr;
    word_t          pc;
    creg_addr_t     rd;
    word_t          wdata;
    logic           we;
    word_t          hi;
    word_t          lo;
    logic           hi_we;
    logic           lo_we;
  } writeback_data_t;

  typedef struct packed {
    decoded_instr_t instr;
    word_t          pc;
    creg_addr_t     writereg;
    word_t          result;
    word_t          hi;
    word_t          lo;
    logic           reg_wen;
    logic           hi_wen;
    logic           lo_wen;
  } wb_entry_t;

  // Buffered form: pc only needs storage when the trace ports exist.
  typedef struct packed {
    decoded_instr_t instr;
    creg_addr_t     writereg;
    word_t          result;
    word_t          hi;
    word_t          lo;
    logic           reg_wen;
    logic           hi_wen;
    logic           lo_wen;
  } wb_store_t;

  function automatic wb_entry_t wb_entry_from_wbdata(input writeback_data_t d);
    wb_entry_t e;
    e.instr    = d.instr;
    e.pc       = d.pc;
    e.writereg = d.rd;
    e.result   = d.wdata;
    e.hi       = d.hi;
    e.lo       = d.lo;
    e.reg_wen  = d.we;
    e.hi_wen   = d.hi_we;
    e.lo_wen   = d.lo_we;
    return e;
  endfunction

  function automatic wb_store_t wb_pack_store(input wb_entry_t e);
    wb_store_t s;
    s.instr    = e.instr;
    s.writereg = e.writereg;
    s.result   = e.result;
    s.hi       = e.hi;
    s.lo       = e.lo;
    s.reg_wen  = e.reg_wen;
    s.hi_wen   = e.hi_wen;
    s.lo_wen   = e.lo_wen;
    return s;
  endfunction

  function automatic wb_entry_t wb_unpack_store(input wb_store_t s, input word_t pc);
    wb_entry_t e;
    e.instr    = s.instr;
    e.pc       = pc;
    e.writereg = s.writereg;
    e.result   = s.result;
    e.hi       = s.hi;
    e.lo       = s.lo;
    e.reg_wen  = s.reg_wen;
    e.hi_wen   = s.hi_wen;
    e.lo_wen   = s.lo_wen;
    return e;
  endfunction

endpackage

// File: rtl/wb_lookup_unit.sv
// Single-port youngest-match register lookup over the commit-queue buffer.
//
// Ports:
//   i_head      oldest buffered slot
//   i_count     number of valid slots starting at i_head
//   i_reg_wen   per-slot register-write enable
//   i_writereg  per-slot destination register
//   i_result    per-slot result value
//   i_query     register being looked up (r0 never hits)
//   o_hit       some valid slot writes i_query
//   o_data      result of the youngest such slot, 0 on miss
module wb_lookup_unit
  import writeback_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic [PW-1:0]          i_head,
  input  logic [CW-1:0]          i_count,
  input  logic [DEPTH-1:0]       i_reg_wen,
  input  creg_addr_t [DEPTH-1:0] i_writereg,
  input  word_t [DEPTH-1:0]      i_result,
  input  creg_addr_t             i_query,
  output logic                   o_hit,
  output word_t                  o_data
);

  logic [PW-1:0] w_idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the surviving value belongs to the youngest writer.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_idx = i_head + PW'(j);
      if ((CW'(j) < i_count) && i_reg_wen[w_idx] &&
          (i_writereg[w_idx] == i_query) && (i_query != '0)) begin
        o_hit  = 1'b1;
        o_data = i_result[w_idx];
      end
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Multi-lane in-order writeback commit queue.
//
// Accepts up to CH records per cycle into a circular buffer, drains up to CH
// per cycle toward the register file, merges HI/LO writes across the drained
// lanes, and answers RD_PORTS youngest-match bypass lookups.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   in_valid/in_data         enqueue group (contiguous from lane 0, lane 0 oldest)
//   in_ready                 room for a full CH-wide group (pre-drain occupancy)
//   drain_en                 consumer takes drained lanes this cycle
//   out_valid/out_data       head entries, lane 0 oldest
//   hi_wen/hi_data, lo_wen/lo_data   merged HI/LO writes (highest lane wins)
//   query_reg/query_hit/query_data   bypass lookups
//   count                    occupancy
//
// Optional: define WB_COMMIT_QUEUE_TRACE_EN to add debug_wb_pc/wen/wnum/wdata
// trace ports and the pc storage they need.
module wb_commit_queue
  import writeback_pkg::*;
#(
  parameter int CH       = 2,
  parameter int DEPTH    = 8,
  parameter int RD_PORTS = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [CH-1:0]              in_valid,
  input  wb_entry_t [CH-1:0]         in_data,
  output logic                       in_ready,
  input  logic                       drain_en,
  output logic [CH-1:0]              out_valid,
  output wb_entry_t [CH-1:0]         out_data,
  output logic                       hi_wen,
  output word_t                      hi_data,
  output logic                       lo_wen,
  output word_t                      lo_data,
  input  creg_addr_t [RD_PORTS-1:0]  query_reg,
  output logic [RD_PORTS-1:0]        query_hit,
  output word_t [RD_PORTS-1:0]       query_data,
`ifdef WB_COMMIT_QUEUE_TRACE_EN
  output word_t [CH-1:0]             debug_wb_pc,
  output logic [CH-1:0][3:0]         debug_wb_wen,
  output creg_addr_t [CH-1:0]        debug_wb_wnum,
  output word_t [CH-1:0]             debug_wb_wdata,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CH_C    = CW'(CH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  wb_store_t     r_mem [DEPTH];
`ifdef WB_COMMIT_QUEUE_TRACE_EN
  word_t         r_pc  [DEPTH];
`endif

  logic          w_run;
  logic [CW-1:0] w_enq_k;
  logic          w_enq;
  logic [CW-1:0] w_push;
  logic [CW-1:0] w_pop;
  logic [PW-1:0] w_wr_idx [CH];
  logic [PW-1:0] w_rd_idx [CH];

  logic [DEPTH-1:0]       w_slot_wen;
  creg_addr_t [DEPTH-1:0] w_slot_reg;
  word_t [DEPTH-1:0]      w_slot_res;

  assign count    = r_count;
  assign in_ready = (DEPTH_C - r_count) >= CH_C;

  // Enqueue width is the run of leading ones; anything past the first zero
  // is ignored.
  always_comb begin
    w_enq_k = '0;
    w_run   = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (w_run && in_valid[i]) begin
        w_enq_k = w_enq_k + CW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  assign w_enq  = in_ready && in_valid[0];
  assign w_push = w_enq ? w_enq_k : '0;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_wr_idx[i] = r_tail + PW'(i);
    end
  end

  // Drain side: lanes read straight from registered state, so a record
  // written this edge is visible no earlier than the next cycle.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CH; i++) begin
      w_rd_idx[i]  = r_head + PW'(i);
      out_valid[i] = drain_en && (r_count > CW'(i));
      if (out_valid[i]) begin
        w_pop = w_pop + CW'(1);
      end
`ifdef WB_COMMIT_QUEUE_TRACE_EN
      out_data[i] = wb_unpack_store(r_mem[w_rd_idx[i]], r_pc[w_rd_idx[i]]);
`else
      out_data[i] = wb_unpack_store(r_mem[w_rd_idx[i]], '0);
`endif
    end
  end

  // Pointers and occupancy; only the control state is reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + w_push - w_pop;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (w_enq && (CW'(i) < w_enq_k)) begin
        r_mem[w_wr_idx[i]] <= wb_pack_store(in_data[i]);
`ifdef WB_COMMIT_QUEUE_TRACE_EN
        r_pc[w_wr_idx[i]]  <= in_data[i].pc;
`endif
      end
    end
  end

  // The consumer resolves same-register conflicts in favour of the higher
  // lane, so HI/LO take the value from the highest drained writer.
  always_comb begin
    hi_wen  = 1'b0;
    hi_data = '0;
    lo_wen  = 1'b0;
    lo_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (out_valid[i] && out_data[i].hi_wen) begin
        hi_wen  = 1'b1;
        hi_data = out_data[i].hi;
      end
      if (out_valid[i] && out_data[i].lo_wen) begin
        lo_wen  = 1'b1;
        lo_data = out_data[i].lo;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      w_slot_wen[s] = r_mem[s].reg_wen;
      w_slot_reg[s] = r_mem[s].writereg;
      w_slot_res[s] = r_mem[s].result;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_lookup
    wb_lookup_unit #(
      .DEPTH (DEPTH)
    ) u_lookup (
      .i_head     (r_head),
      .i_count    (r_count),
      .i_reg_wen  (w_slot_wen),
      .i_writereg (w_slot_reg),
      .i_result   (w_slot_res),
      .i_query    (query_reg[p]),
      .o_hit      (query_hit[p]),
      .o_data     (query_data[p])
    );
  end

`ifdef WB_COMMIT_QUEUE_TRACE_EN
  // Gated by out_valid, which is low whenever reset holds count at zero.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      debug_wb_wen[i]   = {4{out_valid[i] && out_data[i].reg_wen}};
      debug_wb_pc[i]    = out_valid[i] ? out_data[i].pc       : '0;
      debug_wb_wnum[i]  = out_valid[i] ? out_data[i].writereg : '0;
      debug_wb_wdata[i] = out_valid[i] ? out_data[i].result   : '0;
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^in_data;
`endif

  a_in_valid_contig: assert property (@(posedge clk) disable iff (!resetn)
    ((in_valid & (in_valid + CH'(1))) == '0));

  a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
    (r_count <= DEPTH_C));

endmodule
